// File: rtl/mul16_share_arb_if.sv
// Request/operand/grant/result bundle shared by the two requesting ports and the
// shared multiplier.
interface mul16_share_arb_if #(
  parameter int DW = 8
);
  logic            req0;
  logic            req1;
  logic [2*DW-1:0] a0;
  logic [2*DW-1:0] b0;
  logic [2*DW-1:0] a1;
  logic [2*DW-1:0] b1;
  logic            gnt0;
  logic            gnt1;
  logic            done0;
  logic            done1;
  logic [4*DW-1:0] result;
  logic            busy;

  modport master (
    output req0, req1, a0, b0, a1, b1,
    input  gnt0, gnt1, done0, done1, result, busy
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1,
    output gnt0, gnt1, done0, done1, result, busy
  );
endinterface

// File: rtl/mul16_share_arb.sv
// Two-port round-robin arbiter in front of one DW x DW multiplier. Each 2DW x 2DW
// product is built from four partial products over four cycles.
module mul16_share_arb #(
  parameter int DW = 8
) (
  input logic              clk,
  input logic              rst,
  mul16_share_arb_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    MUL0,
    MUL1,
    MUL2,
    MUL3,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            ptr;
  logic            port_id;
  logic [2*DW-1:0] op_a;
  logic [2*DW-1:0] op_b;
  logic [4*DW-1:0] acc;
  logic [4*DW-1:0] result_q;

  logic            any_req;
  logic            grant_port;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_b;
  logic [2*DW-1:0] prod;
  logic [4*DW-1:0] partial;
  logic [4*DW-1:0] acc_base;
  logic [4*DW-1:0] acc_sum;

  // When both ports ask, the pointer decides; otherwise the lone requester wins.
  always_comb begin
    any_req    = bus.req0 | bus.req1;
    grant_port = (bus.req0 && bus.req1) ? ptr : bus.req1;
  end

  always_comb begin
    state_next = state;
    bus.gnt0   = 1'b0;
    bus.gnt1   = 1'b0;
    bus.done0  = 1'b0;
    bus.done1  = 1'b0;
    bus.busy   = (state != IDLE);
    case (state)
      IDLE: if (any_req) state_next = MUL0;
      MUL0: begin
        state_next = MUL1;
        bus.gnt0   = ~port_id;
        bus.gnt1   = port_id;
      end
      MUL1: state_next = MUL2;
      MUL2: state_next = MUL3;
      MUL3: state_next = DONE;
      DONE: begin
        state_next = IDLE;
        bus.done0  = ~port_id;
        bus.done1  = port_id;
      end
      default: state_next = IDLE;
    endcase
  end

  // One multiplier and one adder: the state only steers operand halves and shift.
  always_comb begin
    mul_a    = '0;
    mul_b    = '0;
    acc_base = acc;
    case (state)
      MUL0: begin
        mul_a    = op_a[DW-1:0];
        mul_b    = op_b[DW-1:0];
        acc_base = '0;
      end
      MUL1: begin
        mul_a = op_a[2*DW-1:DW];
        mul_b = op_b[DW-1:0];
      end
      MUL2: begin
        mul_a = op_a[DW-1:0];
        mul_b = op_b[2*DW-1:DW];
      end
      MUL3: begin
        mul_a = op_a[2*DW-1:DW];
        mul_b = op_b[2*DW-1:DW];
      end
      default: ;
    endcase
    prod = (2*DW)'(mul_a) * (2*DW)'(mul_b);
    case (state)
      MUL1, MUL2: partial = (4*DW)'(prod) << DW;
      MUL3:       partial = (4*DW)'(prod) << (2*DW);
      default:    partial = (4*DW)'(prod);
    endcase
    acc_sum = acc_base + partial;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operands are frozen at grant time so later bus changes cannot disturb the product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= 1'b0;
      port_id  <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        port_id <= grant_port;
        ptr     <= ~grant_port;
        op_a    <= grant_port ? bus.a1 : bus.a0;
        op_b    <= grant_port ? bus.b1 : bus.b0;
      end
      if (state == MUL0 || state == MUL1 || state == MUL2 || state == MUL3) begin
        acc <= acc_sum;
      end
      if (state == MUL3) begin
        result_q <= acc_sum;
      end
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_mul16_share_arb.sv
// Directed bench for mul16_share_arb: reset, products, round-robin order, latency,
// mid-operation reset abort and operand stability.
module tb_mul16_share_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   check_cnt = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  mul16_share_arb_if #(.DW(8)) bus ();

  mul16_share_arb #(.DW(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.done0 || bus.done1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic r0, input logic r1,
                               input logic [15:0] va0, input logic [15:0] vb0,
                               input logic [15:0] va1, input logic [15:0] vb1);
    bus.req0 = r0;
    bus.req1 = r1;
    bus.a0   = va0;
    bus.b0   = vb0;
    bus.a1   = va1;
    bus.b1   = vb1;
  endtask

  task automatic waitGnt(input int limit, output int n);
    bit found = 1'b0;
    n = 0;
    for (int i = 0; i < limit && !found; i++) begin
      tick();
      n++;
      if (bus.gnt0 || bus.gnt1) found = 1'b1;
    end
    checkOutput("gnt_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic waitDone(input int limit, output int n);
    bit found = 1'b0;
    n = 0;
    for (int i = 0; i < limit && !found; i++) begin
      tick();
      n++;
      if (bus.done0 || bus.done1) found = 1'b1;
    end
    checkOutput("done_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int n_g;
    int n_d;
    int done_before;
    int order[4];

    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tick();
    tick();
    checkOutput("rst_busy",   {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_result", bus.result, 32'd0);
    checkOutput("rst_pulses", {28'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 32'd0);
    rst = 1'b1;
    tick();

    // Port 0: 0x1234 * 0x5678
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h5678, 16'h0000, 16'h0000);
    busy_cnt = 0;
    waitGnt(10, n_g);
    checkOutput("p0_gnt0", {31'd0, bus.gnt0}, 32'd1);
    checkOutput("p0_gnt1", {31'd0, bus.gnt1}, 32'd0);
    bus.req0 = 1'b0;
    waitDone(10, n_d);
    checkOutput("p0_done0",   {31'd0, bus.done0}, 32'd1);
    checkOutput("p0_latency", n_d, 32'd4);
    checkOutput("p0_result",  bus.result, 32'h06260060);
    tick();
    checkOutput("p0_busy_idle", {31'd0, bus.busy}, 32'd0);
    checkOutput("p0_busy_cnt",  busy_cnt, 32'd5);
    checkOutput("p0_result_hold", bus.result, 32'h06260060);

    // Port 1: 0xFFFF * 0xFFFF, then 0 * 0xBEEF
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
    waitGnt(10, n_g);
    checkOutput("p1_gnt1", {31'd0, bus.gnt1}, 32'd1);
    bus.req1 = 1'b0;
    waitDone(10, n_d);
    checkOutput("p1_done1",  {31'd0, bus.done1}, 32'd1);
    checkOutput("p1_result", bus.result, 32'hFFFE0001);
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF);
    waitGnt(10, n_g);
    bus.req1 = 1'b0;
    waitDone(10, n_d);
    checkOutput("p1_zero_result", bus.result, 32'h00000000);

    // Operand change after capture must not leak into the product
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h5678, 16'h0000, 16'h0000);
    waitGnt(10, n_g);
    bus.req0 = 1'b0;
    tick();
    bus.a0 = 16'h0000;
    waitDone(10, n_d);
    checkOutput("stable_result", bus.result, 32'h06260060);

    // Simultaneous requests right after reset
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0002, 16'h0003, 16'h0100, 16'h0100);
    waitGnt(10, n_g);
    checkOutput("both_first_gnt0", {31'd0, bus.gnt0}, 32'd1);
    checkOutput("both_first_gnt1", {31'd0, bus.gnt1}, 32'd0);
    bus.req0 = 1'b0;
    waitDone(10, n_d);
    checkOutput("both_done0",  {31'd0, bus.done0}, 32'd1);
    checkOutput("both_result0", bus.result, 32'h00000006);
    waitGnt(10, n_g);
    checkOutput("both_second_gnt1", {31'd0, bus.gnt1}, 32'd1);
    bus.req1 = 1'b0;
    waitDone(10, n_d);
    checkOutput("both_done1",   {31'd0, bus.done1}, 32'd1);
    checkOutput("both_result1", bus.result, 32'h00010000);
    checkOutput("both_spacing", n_g + n_d, 32'd6);

    // Both held high: grants must alternate
    applyStimulus(1'b1, 1'b1, 16'h0002, 16'h0003, 16'h0100, 16'h0100);
    for (int k = 0; k < 4; k++) begin
      waitGnt(10, n_g);
      order[k] = bus.gnt1 ? 1 : 0;
      checkOutput("rr_single_gnt", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
      waitDone(10, n_d);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    checkOutput("rr_order0", order[0], 32'd0);
    checkOutput("rr_order1", order[1], 32'd1);
    checkOutput("rr_order2", order[2], 32'd0);
    checkOutput("rr_order3", order[3], 32'd1);
    tick();

    // Reset during MUL2 aborts with no done pulse
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h5678, 16'h0000, 16'h0000);
    waitGnt(10, n_g);
    bus.req0 = 1'b0;
    tick();
    tick();
    done_before = done_cnt;
    rst = 1'b0;
    #1;
    checkOutput("abort_busy",   {31'd0, bus.busy}, 32'd0);
    checkOutput("abort_result", bus.result, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    checkOutput("abort_no_done", done_cnt - done_before, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h0000);
    waitGnt(10, n_g);
    checkOutput("after_rst_gnt0", {31'd0, bus.gnt0}, 32'd1);
    bus.req0 = 1'b0;
    waitDone(10, n_d);
    checkOutput("after_rst_result", bus.result, 32'h0000000F);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mul16_share_arb.md
MUL16_SHARE_ARB -- requirements
Module: mul16_share_arb

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the half-operand width; operands are 2*DW bits and the result is 4*DW bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each: level requests from port 0 and port 1.
REQ-005 The block SHALL have ports a0, b0, a1, b1, input, 2*DW bits each: unsigned operands for each port.
REQ-006 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle grant pulses.
REQ-007 The block SHALL have ports done0 and done1, output, 1 bit each: one-cycle completion pulses.
REQ-008 The block SHALL have port result, output, 4*DW bits: product of the last completed operation, shared by both ports.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 The block SHALL contain exactly one DW x DW unsigned multiplier and one accumulator adder, each used at most once per cycle.
REQ-011 The FSM SHALL have states IDLE, MUL0, MUL1, MUL2, MUL3 and DONE.
REQ-012 Transitions SHALL be: IDLE->MUL0 when any request is sampled high, otherwise stay; MUL0->MUL1->MUL2->MUL3->DONE unconditionally; DONE->IDLE.
REQ-013 On the IDLE->MUL0 edge, the block SHALL capture the granted port's a and b into internal registers and record the granted port ID.
REQ-014 Arbitration SHALL be round-robin: if only one port requests, that port wins; if both request, the port named by the priority pointer wins.
REQ-015 After each grant, the pointer SHALL move to the non-granted port.
REQ-016 gnt_x SHALL be high only during the MUL0 cycle of a port-x operation.
REQ-017 done_x SHALL be high only during the DONE cycle of a port-x operation.
REQ-018 Accumulation, with aH/aL and bH/bL as the operand halves: MUL0 acc = aL*bL; MUL1 acc += (aH*bL)<<DW; MUL2 acc += (aL*bH)<<DW; MUL3 acc += (aH*bH)<<2DW.
REQ-019 The accumulator SHALL be 4*DW bits, with no overflow or truncation of the exact unsigned product.
REQ-020 result SHALL load acc on the MUL3->DONE edge and hold until the next such edge.
REQ-021 Latency SHALL be 4 cycles from the rising gnt_x to the rising done_x; throughput SHALL be one operation per 6 cycles, including the mandatory IDLE bubble.
REQ-022 Requests SHALL be sampled only in IDLE; requests arriving or dropping in MUL0..DONE SHALL NOT affect the current operation.
REQ-023 A request dropped mid-operation SHALL still receive its done pulse.
REQ-024 Operand changes after capture SHALL NOT affect the result.

Reset
REQ-025 While rst=0, the block SHALL asynchronously force state IDLE, pointer to port 0, result to 0, acc and the operand registers to 0, and gnt0, gnt1, done0, done1 and busy to 0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-027 After reset deasserts, the first sampled request SHALL be processed normally.

Verification
REQ-028 Scenario: reset, then req0 with a0=0x1234, b0=0x5678 -> gnt0 pulses, done0 pulses 4 cycles later, result=0x06260060, busy high for exactly 5 cycles.
REQ-029 Scenario: req1 with a1=0xFFFF, b1=0xFFFF -> done1 pulses with result=0xFFFE0001; a1=0x0000, b1=0xBEEF -> result=0x00000000.
REQ-030 Scenario: immediately after reset, req0 and req1 rise in the same cycle with a1=b1=0x0100 -> port 0 is granted first, then port 1 on the next IDLE sample; second result=0x00010000; done0 precedes done1 by 6 cycles.
REQ-031 Scenario: both requests held high for 4 operations -> grant order 0,1,0,1; no port is granted twice in a row.
REQ-032 Scenario: rst pulsed low during MUL2 -> busy=0, result=0, no done pulse; then req0 with a0=0x0003, b0=0x0005 -> result=0x0000000F.
REQ-033 Scenario: a0 changed to 0x0000 during MUL1 of a 0x1234*0x5678 operation -> result remains 0x06260060.
